div_writeback_stage: RTL and testbench
======================================

# div_writeback_stage

Buffering and write-back stage directly downstream of the ALU divider. It captures each divider result (quotient, residue, N/C/V) together with its destination information into a 2-entry FIFO. It retires each entry to the register-file write port in one or two beats: the quotient first, then optionally the residue. On retirement it updates the architectural NZCV flag register. Z is computed here, because the divider does not drive it.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; fixed at 2, no other value supported
- RW, 4, register-index width (16 registers)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  divider result present
- in_ready  out  1  stage can accept; equals (count < 2)
- in_quotient  in  32  divider quotient
- in_residue  in  32  divider residue
- in_n, in_c, in_v  in  1 each  divider flags
- in_dz  in  1  divide-by-zero; quotient/residue meaningless
- in_rd  in  RW  destination of quotient
- in_wr_res  in  1  also write residue to (in_rd+1) mod 16
- in_s  in  1  update flags on retirement
- wb_valid  out  1  write-back beat presented
- wb_ready  in  1  register file accepts beat
- wb_rd  out  RW  write index
- wb_data  out  32  write data
- flags  out  4  architectural {N,Z,C,V}
- dz_err  out  1  sticky divide-by-zero indicator

## Operation
- Push when in_valid && in_ready. All in_* fields are stored in the tail entry; count increments.
- in_ready depends only on count. When full, a push is refused even in a cycle that pops; there is no pass-through.
- The head entry retires through a beat counter `beat` ∈ {0,1}, giving states IDLE (count=0), Q_BEAT (beat=0), R_BEAT (beat=1).
- Q_BEAT:
  - wb_valid=1 unless head.dz, with wb_rd=head.rd and wb_data=head.quotient.
  - On wb_ready: if head.wr_res, go to R_BEAT. Otherwise pop and return to Q_BEAT or IDLE.
- R_BEAT:
  - wb_valid=1, wb_rd=head.rd+1 (4-bit wrap, 15→0), wb_data=head.residue.
  - On wb_ready: pop, beat←0.
- dz entries:
  - No write beat is issued (wb_valid=0).
  - The entry pops in the cycle after it reaches the head, regardless of wb_ready.
  - dz_err←1 and stays set until reset.
  - Flags are not updated, even if s=1.
- Flag update happens on the pop of a non-dz entry with s=1: N←head.n, Z←(head.quotient==0), C←head.c, V←head.v.
- Flags are not updated on pops with s=0.
- Push and pop in the same cycle with count=1: count stays 1, the new entry becomes the head next cycle, and beat resets to 0.
- wb_data and wb_rd are 0 whenever wb_valid=0.

## Timing
- Reset (rst_n=0 at a clk edge):
  - count=0, beat=0, FIFO pointers=0.
  - flags=4'b0000, dz_err=0, wb_valid=0, wb_rd=0, wb_data=0, in_ready=0 during reset.
  - Reset mid-operation discards all entries and any pending R_BEAT.
  - in_ready=1 on the first cycle after release.
- Latency: an entry pushed at edge k presents its Q_BEAT wb_valid in cycle k+1 if the FIFO was empty (registered output, no comb path from in_* to wb_*).
- Throughput: one beat per cycle under continuous wb_ready. A wr_res entry occupies 2 cycles, a plain entry 1, a dz entry 1.
- wb_valid, once high, holds with stable wb_rd/wb_data until wb_ready is sampled high.
- flags change on the same edge that pops the head.
- Full: count=2 → in_ready=0. Empty: wb_valid=0.

## Test plan
- Reset then single push (q=5, r=1, rd=3, wr_res=0, s=1, n=c=v=0) with wb_ready=1 → one beat rd=3 data=5 at cycle k+1; flags=0000; in_ready stays 1.
- Push (q=0, r=7, rd=15, wr_res=1, s=1, c=1) → beats (15,0) then (0,7); flags=0110 after second beat.
- Three back-to-back pushes with wb_ready=0 → first two accepted, in_ready=0 on third; raising wb_ready drains both in order, and the third is accepted only when count<2.
- Push with in_dz=1, s=1 → no wb_valid, dz_err=1 thereafter, flags unchanged; a following normal entry retires normally.
- wb_ready toggled 1-0-1 during an R_BEAT → wb_rd/wb_data held stable while low; pop only on the accepted beat.
- Reset asserted during R_BEAT with count=2 → next cycle count=0, wb_valid=0, flags=0000, dz_err=0.

Source files
------------

// File: rtl/div_writeback_stage.sv
//==============================================================================
// Module      : div_writeback_stage
// Description : Two-entry buffer behind the divider. Each result retires to
//               the register-file write port as a quotient beat, optionally
//               followed by a residue beat to rd+1. Retirement updates the
//               NZCV flags; divide-by-zero results are dropped and latch a
//               sticky error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_writeback_stage #(
    parameter int DEPTH = 2,
    parameter int RW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_quotient,
    input  logic [31:0]   in_residue,
    input  logic          in_n,
    input  logic          in_c,
    input  logic          in_v,
    input  logic          in_dz,
    input  logic [RW-1:0] in_rd,
    input  logic          in_wr_res,
    input  logic          in_s,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [RW-1:0] wb_rd,
    output logic [31:0]   wb_data,
    output logic [3:0]    flags,
    output logic          dz_err
);

    // The pointer logic below is 1 bit wide, so only two entries are handled.
    localparam logic [1:0] c_DEPTH = 2'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_Q    = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [1:0]    r_count;
    logic [1:0]    w_count_nxt;
    logic          r_wptr;
    logic          r_rptr;

    logic [31:0]   r_quot   [0:1];
    logic [31:0]   r_res    [0:1];
    logic [RW-1:0] r_rd     [0:1];
    logic          r_n      [0:1];
    logic          r_c      [0:1];
    logic          r_v      [0:1];
    logic          r_dz     [0:1];
    logic          r_wr_res [0:1];
    logic          r_s      [0:1];

    logic [3:0]    r_flags;
    logic          r_dz_err;

    logic          w_push;
    logic          w_pop;
    logic          w_to_r;
    logic          w_wb_valid;
    logic [RW-1:0] w_wb_rd;
    logic [31:0]   w_wb_data;

    // Ready depends only on occupancy; held low while reset is asserted.
    assign in_ready = rst_n && (r_count < c_DEPTH);
    assign w_push   = in_valid && in_ready;

    assign wb_valid = w_wb_valid;
    assign wb_rd    = w_wb_rd;
    assign wb_data  = w_wb_data;
    assign flags    = r_flags;
    assign dz_err   = r_dz_err;

    // Beat sequencing: presents the head entry and decides pop / residue beat.
    always_comb begin
        w_pop       = 1'b0;
        w_to_r      = 1'b0;
        w_wb_valid  = 1'b0;
        w_wb_rd     = '0;
        w_wb_data   = '0;
        if (rst_n) begin
            case (r_state)
                S_Q: begin
                    if (r_dz[r_rptr]) begin
                        // Divide-by-zero results never reach the register file.
                        w_pop = 1'b1;
                    end else begin
                        w_wb_valid = 1'b1;
                        w_wb_rd    = r_rd[r_rptr];
                        w_wb_data  = r_quot[r_rptr];
                        if (wb_ready) begin
                            if (r_wr_res[r_rptr]) begin
                                w_to_r = 1'b1;
                            end else begin
                                w_pop = 1'b1;
                            end
                        end
                    end
                end
                S_R: begin
                    w_wb_valid = 1'b1;
                    w_wb_rd    = r_rd[r_rptr] + 1'b1;
                    w_wb_data  = r_res[r_rptr];
                    if (wb_ready) begin
                        w_pop = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

        // A pop always returns to the quotient beat of whatever is next.
        if (w_count_nxt == 2'd0) begin
            w_state_nxt = S_IDLE;
        end else if (w_to_r || (r_state == S_R && !w_pop)) begin
            w_state_nxt = S_R;
        end else begin
            w_state_nxt = S_Q;
        end
    end

    // Beat state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    // FIFO storage; contents are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_quot[r_wptr]   <= in_quotient;
            r_res[r_wptr]    <= in_residue;
            r_rd[r_wptr]     <= in_rd;
            r_n[r_wptr]      <= in_n;
            r_c[r_wptr]      <= in_c;
            r_v[r_wptr]      <= in_v;
            r_dz[r_wptr]     <= in_dz;
            r_wr_res[r_wptr] <= in_wr_res;
            r_s[r_wptr]      <= in_s;
        end
    end

    // Architectural flags and sticky divide-by-zero, updated on head pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags  <= 4'b0000;
            r_dz_err <= 1'b0;
        end else if (w_pop) begin
            if (r_dz[r_rptr]) begin
                r_dz_err <= 1'b1;
            end else if (r_s[r_rptr]) begin
                r_flags <= {r_n[r_rptr], (r_quot[r_rptr] == 32'd0),
                            r_c[r_rptr], r_v[r_rptr]};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_writeback_stage.sv
//==============================================================================
// Module      : tb_div_writeback_stage
// Description : Scoreboard bench for div_writeback_stage. Directed pushes
//               queue their expected write beats; a monitor pops and checks
//               every accepted beat.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_quotient;
    logic [31:0] in_residue;
    logic        in_n, in_c, in_v, in_dz;
    logic [3:0]  in_rd;
    logic        in_wr_res;
    logic        in_s;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic        dz_err;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];

    div_writeback_stage #(.DEPTH(2), .RW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_quotient (in_quotient),
        .in_residue  (in_residue),
        .in_n        (in_n),
        .in_c        (in_c),
        .in_v        (in_v),
        .in_dz       (in_dz),
        .in_rd       (in_rd),
        .in_wr_res   (in_wr_res),
        .in_s        (in_s),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flags       (flags),
        .dz_err      (dz_err)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            tests = tests + 1;
            if (sb.size() == 0) begin
                failed = failed + 1;
                $display("FAIL beat_unexpected: got rd=%0d data=%0d, required none", wb_rd, wb_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    failed = failed + 1;
                    $display("FAIL beat: got rd=%0d data=%0d, required rd=%0d data=%0d",
                             wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] q, input logic [31:0] r, input logic [3:0] rd,
                         input logic wr, input logic s, input logic n, input logic c,
                         input logic v, input logic dz);
        in_valid    = 1'b1;
        in_quotient = q;
        in_residue  = r;
        in_rd       = rd;
        in_wr_res   = wr;
        in_s        = s;
        in_n        = n;
        in_c        = c;
        in_v        = v;
        in_dz       = dz;
    endtask

    task automatic expect_beat(input logic [3:0] rd, input logic [31:0] data);
        beat_t b;
        b.rd   = rd;
        b.data = data;
        sb.push_back(b);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wb_ready  = 1'b0;
        drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_flags",    64'(flags),    64'd0);
        chk("rst_dz_err",   64'(dz_err),   64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single plain push, one-cycle latency
        wb_ready = 1'b1;
        drive(32'd5, 32'd1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_beat(4'd3, 32'd5);
        tick();
        in_valid = 1'b0;
        chk("lat_wb_valid", 64'(wb_valid), 64'd1);
        tick();
        chk("single_flags", 64'(flags), 64'd0);
        chk("single_in_ready", 64'(in_ready), 64'd1);
        drain("single_drain");

        // Quotient + residue with register wrap; Z from zero quotient
        drive(32'd0, 32'd7, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_beat(4'd15, 32'd0);
        expect_beat(4'd0, 32'd7);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wr_res_flags_mid", 64'(flags), 64'd0);
        tick();
        chk("wr_res_flags", 64'(flags), 64'b0110);
        drain("wr_res_drain");

        // Back-pressure: two accepted, third waits for space
        wb_ready = 1'b0;
        drive(32'd11, 32'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_beat(4'd1, 32'd11);
        tick();
        drive(32'd22, 32'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_beat(4'd2, 32'd22);
        tick();
        drive(32'd33, 32'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("full_in_ready_hold", 64'(in_ready), 64'd0);
        chk("full_head_rd", 64'(wb_rd), 64'd1);
        wb_ready = 1'b1;
        begin
            bit accepted;
            accepted = 1'b0;
            for (int i = 0; i < 10 && !accepted; i++) begin
                if (in_ready) begin
                    expect_beat(4'd4, 32'd33);
                    accepted = 1'b1;
                end
                tick();
            end
            chk("third_accepted", 64'(accepted), 64'd1);
        end
        in_valid = 1'b0;
        drain("bp_drain");
        chk("bp_flags", 64'(flags), 64'b0110);

        // Divide-by-zero entry followed by a normal one
        drive(32'd0, 32'd0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'd9, 32'd0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_beat(4'd6, 32'd9);
        chk("dz_wb_valid", 64'(wb_valid), 64'd0);
        chk("dz_err_pre", 64'(dz_err), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("dz_err_set", 64'(dz_err), 64'd1);
        chk("dz_flags_kept", 64'(flags), 64'b0110);
        chk("dz_next_valid", 64'(wb_valid), 64'd1);
        drain("dz_drain");
        chk("dz_next_flags", 64'(flags), 64'b1000);
        chk("dz_err_sticky", 64'(dz_err), 64'd1);

        // Residue beat held under back-pressure
        drive(32'd100, 32'd200, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_beat(4'd7, 32'd100);
        expect_beat(4'd8, 32'd200);
        tick();
        in_valid = 1'b0;
        tick();
        wb_ready = 1'b0;
        chk("hold_rd_a", 64'({wb_valid, wb_rd, wb_data}), {27'd0, 1'b1, 4'd8, 32'd200});
        tick();
        chk("hold_rd_b", 64'({wb_valid, wb_rd, wb_data}), {27'd0, 1'b1, 4'd8, 32'd200});
        wb_ready = 1'b1;
        tick();
        chk("hold_popped", 64'(wb_valid), 64'd0);
        chk("hold_flags", 64'(flags), 64'b1000);
        drain("hold_drain");

        // Reset during a residue beat with a second entry queued
        drive(32'd1, 32'd2, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_beat(4'd9, 32'd1);
        tick();
        drive(32'd3, 32'd0, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        wb_ready = 1'b0;
        chk("rbeat_full", 64'({in_ready, wb_valid, wb_rd, wb_data}),
            {26'd0, 1'b0, 1'b1, 4'd10, 32'd2});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 64'({in_ready, wb_valid}), 64'd0);
        tick();
        rst_n = 1'b1;
        wb_ready = 1'b1;
        #1;
        chk("after_rst_state", 64'({in_ready, wb_valid, flags, dz_err}), 64'b1000000);
        tick();
        chk("after_rst_empty", 64'(wb_valid), 64'd0);
        chk("sb_empty_final", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
